// File: rtl/mult2_hilo.sv
// mult2_hilo: second stage of the two-stage 32x32 multiplier.
// Takes the sixteen 8x8 partial products from stage 1, reduces them to a
// 64-bit product, applies two's-complement correction for signed operands,
// and writes (MUL), accumulates (MADD) or subtracts (MSUB) into HI/LO.
// HI/LO are also written directly by MTHI/MTLO. A multiply writeback beats
// an MT write that lands on the same edge.
//
// Build option: define MULT2_PIPE_EN to register the upper and lower partial
// sums separately. This adds one cycle of latency. Throughput stays at one
// result per cycle. With the macro undefined, latency is two cycles.
module mult2_hilo (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        In_Valid,
  input  logic        Stall,
  input  logic [1:0]  Op,
  input  logic        Signed,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [15:0] SubOut0,
  input  logic [15:0] SubOut1,
  input  logic [15:0] SubOut2,
  input  logic [15:0] SubOut3,
  input  logic [15:0] SubOut4,
  input  logic [15:0] SubOut5,
  input  logic [15:0] SubOut6,
  input  logic [15:0] SubOut7,
  input  logic [15:0] SubOut8,
  input  logic [15:0] SubOut9,
  input  logic [15:0] SubOut10,
  input  logic [15:0] SubOut11,
  input  logic [15:0] SubOut12,
  input  logic [15:0] SubOut13,
  input  logic [15:0] SubOut14,
  input  logic [15:0] SubOut15,
  input  logic        MtHi,
  input  logic        MtLo,
  input  logic [31:0] Wr_Data,
  output logic [31:0] Hi,
  output logic [31:0] Lo,
  output logic        Busy,
  output logic        Done
);

  // The reserved encoding 2'b11 executes as MUL.
  typedef enum logic [1:0] {
    OP_MUL  = 2'b00,
    OP_MADD = 2'b01,
    OP_MSUB = 2'b10,
    OP_RSVD = 2'b11
  } op_e;

  // Partial products gathered into an array.
  // Element 4*i+j holds A byte i times B byte j, where byte 0 is bits 31:24.
  logic [15:0] pp_in [16];

  assign pp_in[0]  = SubOut0;
  assign pp_in[1]  = SubOut1;
  assign pp_in[2]  = SubOut2;
  assign pp_in[3]  = SubOut3;
  assign pp_in[4]  = SubOut4;
  assign pp_in[5]  = SubOut5;
  assign pp_in[6]  = SubOut6;
  assign pp_in[7]  = SubOut7;
  assign pp_in[8]  = SubOut8;
  assign pp_in[9]  = SubOut9;
  assign pp_in[10] = SubOut10;
  assign pp_in[11] = SubOut11;
  assign pp_in[12] = SubOut12;
  assign pp_in[13] = SubOut13;
  assign pp_in[14] = SubOut14;
  assign pp_in[15] = SubOut15;

  // Stage-1 capture registers
  logic [15:0] pp_q [16];
  logic [15:0] pp_d [16];
  logic [31:0] a_q,   a_d;
  logic [31:0] b_q,   b_d;
  op_e         op_q,  op_d;
  logic        sgn_q, sgn_d;
  logic        v1_q,  v1_d;

  // Architectural state
  logic [31:0] hi_q,   hi_d;
  logic [31:0] lo_q,   lo_d;
  logic        done_q, done_d;

  // Reduction results
  logic [63:0] sum_hi;  // terms with i+j <= 3
  logic [63:0] sum_lo;  // terms with i+j >  3

  // Operation arriving at the writeback edge
  logic        wb_valid;
  logic [63:0] wb_sum;
  logic [31:0] wb_a;
  logic [31:0] wb_b;
  op_e         wb_op;
  logic        wb_sgn;

  // Signed correction.
  // A negative operand read as unsigned adds 2^32 times the other operand
  // to the product. This function returns that excess so it can be removed.
  function automatic logic [63:0] sign_corr(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic        sgn);
    logic [63:0] c;
    c = '0;
    if (sgn && a[31]) c = c + {b, 32'h0};
    if (sgn && b[31]) c = c + {a, 32'h0};
    return c;
  endfunction

  // Stage-1 next state: capture when valid, hold everything while stalled.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch.
    pp_d  = pp_q;
    a_d   = a_q;
    b_d   = b_q;
    op_d  = op_q;
    sgn_d = sgn_q;
    v1_d  = v1_q;
    if (!Stall) begin
      v1_d = In_Valid;
      if (In_Valid) begin
        pp_d  = pp_in;
        a_d   = A;
        b_d   = B;
        op_d  = op_e'(Op);
        sgn_d = Signed;
      end
    end
  end

  // Stage-1 registers
  always_ff @(posedge Clock) begin
    if (Reset) begin
      // NOTE: the partial-product array is plain flops, not a RAM.
      // Clearing it here keeps the captured state deterministic after reset.
      pp_q  <= '{default: '0};
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= OP_MUL;
      sgn_q <= 1'b0;
      v1_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments, so all flops update from pre-edge values.
      pp_q  <= pp_d;
      a_q   <= a_d;
      b_q   <= b_d;
      op_q  <= op_d;
      sgn_q <= sgn_d;
      v1_q  <= v1_d;
    end
  end

  // Partial-product reduction, split into upper and lower halves.
  // Term (i,j) is shifted left by 8*(6-i-j).
  always_comb begin
    sum_hi = '0;
    sum_lo = '0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        if (i + j <= 3)
          sum_hi = sum_hi + (64'(pp_q[4*i+j]) << (8 * (6 - i - j)));
        else
          sum_lo = sum_lo + (64'(pp_q[4*i+j]) << (8 * (6 - i - j)));
      end
    end
  end

`ifdef MULT2_PIPE_EN
  // Stage-2 registers: split sums plus the operands the correction needs
  logic [63:0] sum_hi_q, sum_hi_d;
  logic [63:0] sum_lo_q, sum_lo_d;
  logic [31:0] a2_q,     a2_d;
  logic [31:0] b2_q,     b2_d;
  op_e         op2_q,    op2_d;
  logic        sgn2_q,   sgn2_d;
  logic        v2_q,     v2_d;

  // Stage-2 next state: advance from stage 1 unless stalled.
  always_comb begin
    sum_hi_d = sum_hi_q;
    sum_lo_d = sum_lo_q;
    a2_d     = a2_q;
    b2_d     = b2_q;
    op2_d    = op2_q;
    sgn2_d   = sgn2_q;
    v2_d     = v2_q;
    if (!Stall) begin
      v2_d = v1_q;
      if (v1_q) begin
        sum_hi_d = sum_hi;
        sum_lo_d = sum_lo;
        a2_d     = a_q;
        b2_d     = b_q;
        op2_d    = op_q;
        sgn2_d   = sgn_q;
      end
    end
  end

  // Stage-2 registers
  always_ff @(posedge Clock) begin
    if (Reset) begin
      sum_hi_q <= '0;
      sum_lo_q <= '0;
      a2_q     <= '0;
      b2_q     <= '0;
      op2_q    <= OP_MUL;
      sgn2_q   <= 1'b0;
      v2_q     <= 1'b0;
    end else begin
      sum_hi_q <= sum_hi_d;
      sum_lo_q <= sum_lo_d;
      a2_q     <= a2_d;
      b2_q     <= b2_d;
      op2_q    <= op2_d;
      sgn2_q   <= sgn2_d;
      v2_q     <= v2_d;
    end
  end

  assign wb_valid = v2_q;
  assign wb_sum   = sum_hi_q + sum_lo_q;
  assign wb_a     = a2_q;
  assign wb_b     = b2_q;
  assign wb_op    = op2_q;
  assign wb_sgn   = sgn2_q;
  assign Busy     = v1_q | v2_q;
`else
  assign wb_valid = v1_q;
  assign wb_sum   = sum_hi + sum_lo;
  assign wb_a     = a_q;
  assign wb_b     = b_q;
  assign wb_op    = op_q;
  assign wb_sgn   = sgn_q;
  assign Busy     = v1_q;
`endif

  // Writeback: a multiply result beats an MT write on the same edge.
  // HI/LO are read at this edge, so back-to-back MADDs chain.
  always_comb begin
    logic [63:0] prod;
    logic [63:0] res;
    prod   = wb_sum - sign_corr(wb_a, wb_b, wb_sgn);
    hi_d   = hi_q;
    lo_d   = lo_q;
    done_d = done_q;
    unique case (wb_op)
      OP_MADD: res = {hi_q, lo_q} + prod;
      OP_MSUB: res = {hi_q, lo_q} - prod;
      default: res = prod;
    endcase
    if (!Stall) begin
      done_d = wb_valid;
      if (wb_valid) begin
        {hi_d, lo_d} = res;
      end else begin
        if (MtHi) hi_d = Wr_Data;
        if (MtLo) lo_d = Wr_Data;
      end
    end
  end

  // HI/LO and done registers
  always_ff @(posedge Clock) begin
    if (Reset) begin
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      done_q <= done_d;
    end
  end

  // Done is hidden while stalled. done_q holds across the stall, so the
  // pending pulse appears once Stall drops.
  assign Done = done_q & ~Stall;
  assign Hi   = hi_q;
  assign Lo   = lo_q;

endmodule

// File: tb/tb_mult2_hilo.sv
// Directed testbench for mult2_hilo. The stage-1 partial products are formed
// here from A and B. Expected HI/LO values are hand-computed constants.
module tb_mult2_hilo;

`ifdef MULT2_PIPE_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic        Clock, Reset, In_Valid, Stall, Signed, MtHi, MtLo;
  logic [1:0]  Op;
  logic [31:0] A, B, Wr_Data;
  logic [15:0] sub [16];
  logic [31:0] Hi, Lo;
  logic        Busy, Done;

  int total = 0;
  int bad   = 0;

  mult2_hilo dut (
    .Clock(Clock), .Reset(Reset), .In_Valid(In_Valid), .Stall(Stall),
    .Op(Op), .Signed(Signed), .A(A), .B(B),
    .SubOut0(sub[0]),   .SubOut1(sub[1]),   .SubOut2(sub[2]),   .SubOut3(sub[3]),
    .SubOut4(sub[4]),   .SubOut5(sub[5]),   .SubOut6(sub[6]),   .SubOut7(sub[7]),
    .SubOut8(sub[8]),   .SubOut9(sub[9]),   .SubOut10(sub[10]), .SubOut11(sub[11]),
    .SubOut12(sub[12]), .SubOut13(sub[13]), .SubOut14(sub[14]), .SubOut15(sub[15]),
    .MtHi(MtHi), .MtLo(MtLo), .Wr_Data(Wr_Data),
    .Hi(Hi), .Lo(Lo), .Busy(Busy), .Done(Done)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Stage-1 behaviour: SubOut(4i+j) = A byte i * B byte j, byte 0 = bits 31:24.
  task automatic set_pp(input logic [31:0] a, input logic [31:0] b);
    logic [7:0] ab, bb;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        ab = a[31-8*i -: 8];
        bb = b[31-8*j -: 8];
        sub[4*i+j] = 16'(ab) * 16'(bb);
      end
    end
  endtask

  // Present one operation for one cycle.
  // Called at a negedge; returns at the negedge after the capture edge.
  task automatic issue(input logic [1:0] op, input logic sgn,
                       input logic [31:0] a, input logic [31:0] b);
    Op = op; Signed = sgn; A = a; B = b; set_pp(a, b); In_Valid = 1'b1;
    @(negedge Clock);
    In_Valid = 1'b0;
  endtask

  // Wait for Done, sampling at negedges. n = negedges waited, or -1 on timeout.
  task automatic wait_done(output int n);
    n = 0;
    while (!Done && n < 16) begin
      @(negedge Clock);
      n++;
    end
    if (!Done) n = -1;
  endtask

  // Write both HI and LO through MTHI/MTLO.
  task automatic mt_both(input logic [31:0] hi_v, input logic [31:0] lo_v);
    MtHi = 1'b1; Wr_Data = hi_v;
    @(negedge Clock);
    MtHi = 1'b0; MtLo = 1'b1; Wr_Data = lo_v;
    @(negedge Clock);
    MtLo = 1'b0;
  endtask

  task automatic test_reset;
    Reset = 1'b1;
    repeat (2) @(negedge Clock);
    total++; if (Hi !== 32'h0)  begin bad++; $display("FAIL reset_hi: got %h want 0", Hi); end
    total++; if (Lo !== 32'h0)  begin bad++; $display("FAIL reset_lo: got %h want 0", Lo); end
    total++; if (Busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", Busy); end
    total++; if (Done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", Done); end
    Reset = 1'b0;
    @(negedge Clock);
  endtask

  task automatic test_mul_unsigned;
    int n;
    issue(2'b00, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    total++; if (Busy !== 1'b1) begin bad++; $display("FAIL mulu_busy: got %b want 1", Busy); end
    total++; if (Done !== 1'b0) begin bad++; $display("FAIL mulu_early_done: got %b want 0", Done); end
    wait_done(n);
    total++; if (n != LAT - 1) begin bad++; $display("FAIL mulu_latency: got %0d want %0d", n, LAT - 1); end
    total++; if (Hi !== 32'hFFFF_FFFE) begin bad++; $display("FAIL mulu_hi: got %h want fffffffe", Hi); end
    total++; if (Lo !== 32'h0000_0001) begin bad++; $display("FAIL mulu_lo: got %h want 00000001", Lo); end
    @(negedge Clock);
    total++; if (Done !== 1'b0) begin bad++; $display("FAIL mulu_done_pulse: got %b want 0", Done); end
    total++; if (Busy !== 1'b0) begin bad++; $display("FAIL mulu_busy_end: got %b want 0", Busy); end
  endtask

  task automatic test_mul_signed;
    int n;
    issue(2'b00, 1'b1, 32'hFFFF_FFFF, 32'h0000_0002);
    wait_done(n);
    total++; if (Hi !== 32'hFFFF_FFFF) begin bad++; $display("FAIL muls_hi: got %h want ffffffff", Hi); end
    total++; if (Lo !== 32'hFFFF_FFFE) begin bad++; $display("FAIL muls_lo: got %h want fffffffe", Lo); end
    issue(2'b00, 1'b0, 32'hFFFF_FFFF, 32'h0000_0002);
    wait_done(n);
    total++; if (Hi !== 32'h0000_0001) begin bad++; $display("FAIL mulu2_hi: got %h want 00000001", Hi); end
    total++; if (Lo !== 32'hFFFF_FFFE) begin bad++; $display("FAIL mulu2_lo: got %h want fffffffe", Lo); end
    // (-2) * (-3) = 6
    issue(2'b00, 1'b1, 32'hFFFF_FFFE, 32'hFFFF_FFFD);
    wait_done(n);
    total++; if (Hi !== 32'h0) begin bad++; $display("FAIL mulnn_hi: got %h want 0", Hi); end
    total++; if (Lo !== 32'h6) begin bad++; $display("FAIL mulnn_lo: got %h want 6", Lo); end
    // Reserved op executes as MUL: 3*5 = 15
    issue(2'b11, 1'b0, 32'h3, 32'h5);
    wait_done(n);
    total++; if (Hi !== 32'h0)  begin bad++; $display("FAIL rsvd_hi: got %h want 0", Hi); end
    total++; if (Lo !== 32'hF) begin bad++; $display("FAIL rsvd_lo: got %h want f", Lo); end
  endtask

  task automatic test_back_to_back;
    int pulses;
    MtHi = 1'b1; MtLo = 1'b1; Wr_Data = 32'h0;
    @(negedge Clock);
    MtHi = 1'b0; MtLo = 1'b0;
    Op = 2'b01; Signed = 1'b0; A = 32'd3; B = 32'd4; set_pp(A, B); In_Valid = 1'b1;
    @(negedge Clock);
    A = 32'd5; B = 32'd6; set_pp(A, B);
    @(negedge Clock);
    In_Valid = 1'b0;
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      if (Done === 1'b1) pulses++;
      @(negedge Clock);
    end
    total++; if (pulses != 2) begin bad++; $display("FAIL b2b_pulses: got %0d want 2", pulses); end
    total++; if (Hi !== 32'h0)   begin bad++; $display("FAIL b2b_hi: got %h want 0", Hi); end
    total++; if (Lo !== 32'd42) begin bad++; $display("FAIL b2b_lo: got %0d want 42", Lo); end
  endtask

  task automatic test_msub_wrap;
    int n;
    mt_both(32'h0, 32'h0);
    issue(2'b10, 1'b0, 32'h1, 32'h1);
    wait_done(n);
    total++; if (Hi !== 32'hFFFF_FFFF) begin bad++; $display("FAIL msub_hi: got %h want ffffffff", Hi); end
    total++; if (Lo !== 32'hFFFF_FFFF) begin bad++; $display("FAIL msub_lo: got %h want ffffffff", Lo); end
    // Adding 1 wraps back to zero.
    issue(2'b01, 1'b0, 32'h1, 32'h1);
    wait_done(n);
    total++; if ({Hi, Lo} !== 64'h0) begin bad++; $display("FAIL madd_wrap: got %h want 0", {Hi, Lo}); end
  endtask

  task automatic test_stall;
    int n;
    mt_both(32'h9, 32'h1234_5678);
    issue(2'b00, 1'b0, 32'd7, 32'd9);
    // Stall after capture, with a junk op offered that must be ignored.
    Stall = 1'b1;
    Op = 2'b00; A = 32'h100; B = 32'h100; set_pp(A, B); In_Valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge Clock);
      total++; if (Hi !== 32'h9 || Lo !== 32'h1234_5678)
        begin bad++; $display("FAIL stall_hold%0d: got %h_%h want 00000009_12345678", k, Hi, Lo); end
      total++; if (Done !== 1'b0 || Busy !== 1'b1)
        begin bad++; $display("FAIL stall_flags%0d: got done=%b busy=%b want 0/1", k, Done, Busy); end
    end
    Stall = 1'b0; In_Valid = 1'b0;
    wait_done(n);
    total++; if (n != LAT - 1) begin bad++; $display("FAIL stall_latency: got %0d want %0d", n, LAT - 1); end
    total++; if (Hi !== 32'h0 || Lo !== 32'd63) begin bad++; $display("FAIL stall_result: got %h_%h want 0_3f", Hi, Lo); end
    // Stall in the Done cycle: the pulse is hidden, then re-issued.
    Stall = 1'b1;
    #1;
    total++; if (Done !== 1'b0) begin bad++; $display("FAIL stall_done_mask: got %b want 0", Done); end
    repeat (2) @(negedge Clock);
    Stall = 1'b0;
    #1;
    total++; if (Done !== 1'b1) begin bad++; $display("FAIL stall_done_reissue: got %b want 1", Done); end
    @(negedge Clock);
    total++; if (Done !== 1'b0) begin bad++; $display("FAIL stall_done_once: got %b want 0", Done); end
    total++; if (Lo !== 32'd63) begin bad++; $display("FAIL stall_junk: got %h want 3f", Lo); end
  endtask

  task automatic test_mt_inflight;
    int n;
    // MtLo lands on the capture edge of a MADD. The MADD then reads LO=100.
    MtLo = 1'b1; Wr_Data = 32'd100;
    issue(2'b01, 1'b0, 32'd2, 32'd3);
    MtLo = 1'b0;
    total++; if (Lo !== 32'd100) begin bad++; $display("FAIL mt_write: got %0d want 100", Lo); end
    wait_done(n);
    total++; if (Hi !== 32'h0 || Lo !== 32'd106) begin bad++; $display("FAIL mt_madd: got %h_%h want 0_6a", Hi, Lo); end
  endtask

  task automatic test_collision;
    issue(2'b00, 1'b0, 32'd2, 32'd2);
    repeat (LAT - 2) @(negedge Clock);
    MtHi = 1'b1; MtLo = 1'b1; Wr_Data = 32'hDEAD_BEEF;
    @(negedge Clock);
    MtHi = 1'b0; MtLo = 1'b0;
    total++; if (Done !== 1'b1) begin bad++; $display("FAIL coll_done: got %b want 1", Done); end
    total++; if (Lo !== 32'd4)  begin bad++; $display("FAIL coll_lo: got %h want 4", Lo); end
    total++; if (Hi !== 32'h0)  begin bad++; $display("FAIL coll_hi: got %h want 0", Hi); end
  endtask

  task automatic test_reset_mid;
    int seen;
    issue(2'b00, 1'b0, 32'd5, 32'd5);
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    total++; if (Hi !== 32'h0 || Lo !== 32'h0) begin bad++; $display("FAIL rstmid_hilo: got %h_%h want 0_0", Hi, Lo); end
    total++; if (Busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy: got %b want 0", Busy); end
    seen = 0;
    for (int k = 0; k < 5; k++) begin
      if (Done !== 1'b0) seen++;
      @(negedge Clock);
    end
    total++; if (seen != 0) begin bad++; $display("FAIL rstmid_done: got %0d pulses want 0", seen); end
    total++; if (Lo !== 32'h0) begin bad++; $display("FAIL rstmid_nowb: got %h want 0", Lo); end
  endtask

  initial begin
    Reset = 1'b1; In_Valid = 1'b0; Stall = 1'b0; Signed = 1'b0;
    MtHi = 1'b0; MtLo = 1'b0; Op = 2'b00; A = '0; B = '0; Wr_Data = '0;
    set_pp(32'h0, 32'h0);
    @(negedge Clock);
    test_reset;
    test_mul_unsigned;
    test_mul_signed;
    test_back_to_back;
    test_msub_wrap;
    test_stall;
    test_mt_inflight;
    test_collision;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mult2_hilo.md
Name: mult2_hilo

Overview:
- Second stage of the two-stage multiplier, and the consumer of the first stage's sixteen 8x8 partial products.
- Reduces the partial products to a 64-bit product and applies two's-complement correction for signed operations.
- Optionally accumulates or subtracts the result against the HI/LO register pair, then writes HI/LO.
- Sits in the EX/MEM boundary of the core. HI/LO are read by MFHI/MFLO and written directly by MTHI/MTLO.

Parameters:
- None. Widths are fixed: 32-bit operands, 16-bit partial products, 64-bit result.

Ports:
- Clock  input  1  core clock; all state updates on rising edge
- Reset  input  1  synchronous, active-high reset
- In_Valid  input  1  partial products and operands are valid this cycle
- Stall  input  1  holds the whole pipeline; no state changes except Reset
- Op  input  2  00 MUL, 01 MADD, 10 MSUB, 11 reserved (executes as MUL)
- Signed  input  1  1 = signed operands, 0 = unsigned
- A  input  32  operand A, same value fed to stage 1
- B  input  32  operand B, same value fed to stage 1
- SubOut0..SubOut15  input  16 each  stage-1 partial products; SubOut(4*i+j) = Abyte_i * Bbyte_j, with byte 0 = bits 31:24 and byte 3 = bits 7:0
- MtHi  input  1  write Wr_Data into HI
- MtLo  input  1  write Wr_Data into LO
- Wr_Data  input  32  MTHI/MTLO data
- Hi  output  32  HI register
- Lo  output  32  LO register
- Busy  output  1  a multiply is in flight
- Done  output  1  one-cycle pulse; HI/LO were updated by a multiply on the previous edge

Behaviour:
- Reset: Hi=0, Lo=0, Busy=0, Done=0. Stage-1 valid register and the captured operand/op registers are cleared. Any in-flight operation is discarded with no writeback.
- Stage S1, edge E0 (In_Valid=1, Stall=0): register the 16 partial products, A[31], B[31], A, B, Op and Signed. Set the internal valid bit v1.
- Stage S2, edge E1 (v1=1, Stall=0):
  - P = sum over i,j of SubOut(4i+j) << 8*(6-i-j), computed modulo 2^64.
  - If Signed: subtract (B<<32) when A[31]=1, and subtract (A<<32) when B[31]=1, both modulo 2^64.
  - MUL: {Hi,Lo} <= P.
  - MADD: {Hi,Lo} <= {Hi,Lo} + P.
  - MSUB: {Hi,Lo} <= {Hi,Lo} - P.
  - All arithmetic wraps modulo 2^64; no overflow flag.
- Latency: In_Valid at cycle 0, HI/LO and Done=1 visible in cycle 2.
- Busy=1 while v1=1.
- Back-to-back: In_Valid every cycle is accepted, giving 1 result per cycle.
- MADD immediately following MADD accumulates onto the previous result, because HI/LO is read at the E1 of each op.
- Stall=1: v1, captured registers, Hi and Lo hold. Done is forced to 0 and the pending Done is re-issued after the stall clears. In_Valid is ignored.
- MtHi/MtLo with Stall=0: the register updates on the next edge.
- MtHi/MtLo on the same edge as a multiply writeback: the multiply writeback wins for both Hi and Lo, and the MT write is dropped.
- MtHi/MtLo while v1=1 with no writeback on that edge: the MT write takes effect, and a following MADD/MSUB accumulates onto the written value.
- MtHi and MtLo may assert together; both registers are written.
- Reset mid-operation: takes priority over everything; there is no Done pulse.

Optional Feature:
- MULT2_PIPE_EN defined:
  - Adds a register after partial sums. Register the upper-half sum (terms with i+j<=3) and the lower-half sum (i+j>3) separately, then combine with the signed correction and accumulate on the following edge.
  - Latency becomes 3 cycles; Busy covers both internal stages.
  - Throughput is unchanged; the MT/writeback priority rule is unchanged.
- Undefined: 2-cycle latency as above.

Test Plan:
- MUL unsigned: A=B=0xFFFFFFFF with stage-1 products -> Hi=0xFFFFFFFE, Lo=0x00000001, Done in cycle 2.
- MUL signed: A=0xFFFFFFFF, B=0x00000002 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFFE; the same operands unsigned -> Hi=0x00000001, Lo=0xFFFFFFFE.
- MADD back-to-back after MtHi=1, MtLo=1, Wr_Data=0: MADD 3*4, then MADD 5*6 on consecutive cycles -> Hi=0, Lo=42, two Done pulses.
- MSUB wrap: Hi=Lo=0, MSUB unsigned 1*1 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFFF.
- Stall: MUL 7*9 issued, Stall held 3 cycles after capture -> Hi/Lo unchanged during stall, Lo=63 and Done one cycle after Stall drops.
- Collision and reset: MtLo with Wr_Data=0xDEADBEEF on the writeback edge of MUL 2*2 -> Lo=4. Reset asserted in cycle 1 of a MUL -> Hi=Lo=0, no Done.
